// File: rtl/gf180mcu_fd_sc_mcu7t5v0__dbnc_func_if.sv
// Pad-side signal bundle of the debounce stage: raw level in, filtered level and change pulse out.
interface gf180mcu_fd_sc_mcu7t5v0__dbnc_func_if;
  logic I;
  logic Z;
  logic CHG;

  modport master (output I, input Z, input CHG);
  modport slave  (input I, output Z, output CHG);
endinterface

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__dbnc_func.sv
// Synchronizing debounce filter: resamples a raw pad level into CLK and accepts a new level
// only after LIMIT consecutive disagreeing samples.
module gf180mcu_fd_sc_mcu7t5v0__dbnc_func #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned LIMIT       = 8,
  parameter bit          RST_VAL     = 1'b0
) (
  input  logic CLK,
  input  logic RN,
  inout  wire  VDD,
  inout  wire  VSS,
  gf180mcu_fd_sc_mcu7t5v0__dbnc_func_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LIMIT - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic [CNT_W-1:0]       cnt, cnt_d;
  logic                   z_q, z_d;
  logic                   chg_q, chg_d;

  // Supplies are carried for netlist compatibility only.
  wire unused_supply = VDD ^ VSS;

  assign s = sync[SYNC_STAGES-1];

  // Synchronizer chain; only its last stage feeds the filter.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      sync <= {SYNC_STAGES{RST_VAL}};
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], bus.I};
    end
  end

  // Filter next state: agreement clears the run, the LIMIT-th mismatch is accepted.
  always_comb begin
    z_d   = z_q;
    cnt_d = '0;
    chg_d = 1'b0;
    if (s != z_q) begin
      if (cnt == CNT_LAST) begin
        z_d   = s;
        chg_d = 1'b1;
      end else begin
        cnt_d = cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      z_q   <= RST_VAL;
      cnt   <= '0;
      chg_q <= 1'b0;
    end else begin
      z_q   <= z_d;
      cnt   <= cnt_d;
      chg_q <= chg_d;
    end
  end

  assign bus.Z   = z_q;
  assign bus.CHG = chg_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__dbnc_func.sv
// Scoreboard bench for the debounce filter: stimulus queues expected (level, cycle) for every CHG,
// per-instance monitors pop and compare when CHG is seen.
module tb_gf180mcu_fd_sc_mcu7t5v0__dbnc_func;

  typedef struct {
    logic z;
    int   cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rn_a, rn_b, rn_c;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  wire vdd;
  wire vss;
  assign vdd = 1'b1;
  assign vss = 1'b0;

  gf180mcu_fd_sc_mcu7t5v0__dbnc_func_if ifa ();
  gf180mcu_fd_sc_mcu7t5v0__dbnc_func_if ifb ();
  gf180mcu_fd_sc_mcu7t5v0__dbnc_func_if ifc ();

  // A: defaults. B: LIMIT=1, SYNC_STAGES=3. C: RST_VAL=1.
  gf180mcu_fd_sc_mcu7t5v0__dbnc_func dut_a (
    .CLK(clk), .RN(rn_a), .VDD(vdd), .VSS(vss), .bus(ifa.slave));
  gf180mcu_fd_sc_mcu7t5v0__dbnc_func #(.SYNC_STAGES(3), .LIMIT(1)) dut_b (
    .CLK(clk), .RN(rn_b), .VDD(vdd), .VSS(vss), .bus(ifb.slave));
  gf180mcu_fd_sc_mcu7t5v0__dbnc_func #(.RST_VAL(1'b1)) dut_c (
    .CLK(clk), .RN(rn_c), .VDD(vdd), .VSS(vss), .bus(ifc.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // Monitors: every CHG must match the oldest expected change of that instance.
  always @(negedge clk) begin
    if (ifa.CHG === 1'b1) begin
      total++;
      if (qa.size() == 0) begin
        bad++;
        $display("FAIL a_chg unexpected pulse cyc=%0d z=%b", cyc, ifa.Z);
      end else begin
        exp_t e;
        e = qa.pop_front();
        if (ifa.Z !== e.z || cyc != e.cyc) begin
          bad++;
          $display("FAIL a_chg got z=%b cyc=%0d exp z=%b cyc=%0d", ifa.Z, cyc, e.z, e.cyc);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (ifb.CHG === 1'b1) begin
      total++;
      if (qb.size() == 0) begin
        bad++;
        $display("FAIL b_chg unexpected pulse cyc=%0d z=%b", cyc, ifb.Z);
      end else begin
        exp_t e;
        e = qb.pop_front();
        if (ifb.Z !== e.z || cyc != e.cyc) begin
          bad++;
          $display("FAIL b_chg got z=%b cyc=%0d exp z=%b cyc=%0d", ifb.Z, cyc, e.z, e.cyc);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (ifc.CHG === 1'b1) begin
      total++;
      if (qc.size() == 0) begin
        bad++;
        $display("FAIL c_chg unexpected pulse cyc=%0d z=%b", cyc, ifc.Z);
      end else begin
        exp_t e;
        e = qc.pop_front();
        if (ifc.Z !== e.z || cyc != e.cyc) begin
          bad++;
          $display("FAIL c_chg got z=%b cyc=%0d exp z=%b cyc=%0d", ifc.Z, cyc, e.z, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b cyc=%0d", nm, got, exp, cyc);
    end
  endtask

  function automatic int qsize(input int which);
    case (which)
      0:       return qa.size();
      1:       return qb.size();
      default: return qc.size();
    endcase
  endfunction

  // Bounded wait for all expected changes of one instance to have been seen.
  task automatic drain(input int which, input string nm, input int budget);
    for (int i = 0; i < budget && qsize(which) != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    total++;
    if (qsize(which) != 0) begin
      bad++;
      $display("FAIL %s missing changes left=%0d exp=0 cyc=%0d", nm, qsize(which), cyc);
    end
  endtask

  task automatic push(input int which, input logic z, input int at);
    exp_t e;
    e.z   = z;
    e.cyc = at;
    case (which)
      0:       qa.push_back(e);
      1:       qb.push_back(e);
      default: qc.push_back(e);
    endcase
  endtask

  initial begin
    int t0;
    int t1;
    rn_a = 1'b0; rn_b = 1'b0; rn_c = 1'b0;
    ifa.I = 1'b0; ifb.I = 1'b0; ifc.I = 1'b0;

    // Reset held with inputs toggling: outputs pinned to reset level.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ifa.I = ~ifa.I; ifb.I = ~ifb.I; ifc.I = ~ifc.I;
      chk("rst_a_z", ifa.Z, 1'b0);
      chk("rst_a_chg", ifa.CHG, 1'b0);
      chk("rst_b_z", ifb.Z, 1'b0);
      chk("rst_c_z", ifc.Z, 1'b1);
      chk("rst_c_chg", ifc.CHG, 1'b0);
    end
    @(negedge clk);
    ifa.I = 1'b0; ifb.I = 1'b0; ifc.I = 1'b1;
    rn_a = 1'b1; rn_b = 1'b1; rn_c = 1'b1;

    // Quiet input after release: no change anywhere.
    repeat (20) @(negedge clk);
    chk("idle_a_z", ifa.Z, 1'b0);
    chk("idle_c_z", ifc.Z, 1'b1);

    // Clean rising step then return to 0.
    t0 = cyc;
    ifa.I = 1'b1;
    push(0, 1'b1, t0 + 10);
    while (cyc != t0 + 9) @(negedge clk);
    chk("step_a_z_before", ifa.Z, 1'b0);
    drain(0, "step_rise", 20);
    chk("step_a_z_high", ifa.Z, 1'b1);
    chk("step_a_chg_low", ifa.CHG, 1'b0);
    t0 = cyc;
    ifa.I = 1'b0;
    push(0, 1'b0, t0 + 10);
    drain(0, "step_fall", 20);

    // 7-cycle glitch is rejected.
    ifa.I = 1'b1;
    repeat (7) @(negedge clk);
    ifa.I = 1'b0;
    repeat (15) @(negedge clk);
    chk("glitch7_a_z", ifa.Z, 1'b0);

    // 8-cycle pulse is accepted; the fall needs another full run of mismatches.
    t0 = cyc;
    ifa.I = 1'b1;
    push(0, 1'b1, t0 + 10);
    push(0, 1'b0, t0 + 18);
    repeat (8) @(negedge clk);
    ifa.I = 1'b0;
    drain(0, "pulse8", 30);
    chk("pulse8_a_z", ifa.Z, 1'b0);

    // Reset mid-count: latency restarts from release.
    t0 = cyc;
    ifa.I = 1'b1;
    while (cyc != t0 + 7) @(negedge clk);
    #2 rn_a = 1'b0;
    #1 chk("midrst_a_z", ifa.Z, 1'b0);
    chk("midrst_a_chg", ifa.CHG, 1'b0);
    repeat (2) @(negedge clk);
    rn_a = 1'b1;
    t1 = cyc;
    push(0, 1'b1, t1 + 10);
    while (cyc != t1 + 9) @(negedge clk);
    chk("midrst_a_z_before", ifa.Z, 1'b0);
    drain(0, "midrst", 20);
    chk("midrst_a_z_high", ifa.Z, 1'b1);

    // Asynchronous reset clears an accepted high level without a clock edge.
    #2 rn_a = 1'b0;
    #1 chk("async_a_z", ifa.Z, 1'b0);
    @(negedge clk);
    rn_a = 1'b1;
    t1 = cyc;
    push(0, 1'b1, t1 + 10);
    drain(0, "async_relearn", 20);
    t0 = cyc;
    ifa.I = 1'b0;
    push(0, 1'b0, t0 + 10);
    drain(0, "a_final_fall", 20);

    // LIMIT=1, three sync stages: step then toggling every two cycles, 4-cycle lag.
    t0 = cyc;
    ifb.I = 1'b1;
    push(1, 1'b1, t0 + 4);
    drain(1, "b_step", 10);
    chk("b_step_z", ifb.Z, 1'b1);
    for (int k = 0; k < 6; k++) begin
      t0 = cyc;
      ifb.I = ~ifb.I;
      push(1, ifb.I, t0 + 4);
      repeat (2) @(negedge clk);
    end
    drain(1, "b_toggle", 10);
    chk("b_toggle_z", ifb.Z, 1'b1);

    // RST_VAL=1: falling step takes the full latency.
    t0 = cyc;
    ifc.I = 1'b0;
    push(2, 1'b0, t0 + 10);
    while (cyc != t0 + 9) @(negedge clk);
    chk("c_fall_z_before", ifc.Z, 1'b1);
    drain(2, "c_fall", 20);
    chk("c_fall_z", ifc.Z, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gf180mcu_fd_sc_mcu7t5v0__dbnc_func.md
# gf180mcu_fd_sc_mcu7t5v0__dbnc_func

Synchronizing debounce/glitch-filter stage for asynchronous pad-level inputs. It sits directly upstream of the `buf` drive cells. It resamples a raw input `I` into the `CLK` domain and suppresses pulses shorter than `LIMIT` cycles. It then presents a clean, registered level on `Z` for a buffer stage to drive onto the net.

## Interface
- `SYNC_STAGES`, default 2: synchronizer flop count; legal 2..4.
- `CNT_W`, default 4: debounce counter width.
- `LIMIT`, default 8: consecutive disagreeing cycles required to accept a new level; legal 1..2^`CNT_W`.
- `RST_VAL`, default 1'b0: level of all state flops and `Z` during and after reset.
- `CLK`  input  1  rising-edge clock.
- `RN`  input  1  reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `I`  input  1  raw asynchronous input level.
- `Z`  output  1  filtered, registered level; feeds buffer stage.
- `CHG`  output  1  one-cycle pulse in the cycle `Z` takes a new value.
- `VDD`  inout  1  supply; no functional effect.
- `VSS`  inout  1  ground; no functional effect.

## Operation
- **Synchronizer.** A shift chain `sync[0..SYNC_STAGES-1]` samples `I` on each rising edge of `CLK`. `s = sync[SYNC_STAGES-1]` is the only signal used downstream. `I` never reaches filter logic directly.
- **Filter state.** Register `Z` holds the accepted level. `cnt` (`CNT_W` bits) counts consecutive edges at which `s != Z`.
- **Rules at each rising edge, evaluated against pre-edge values:**
  - If `s == Z`: `cnt <= 0`, `CHG <= 0`.
  - If `s != Z` and `cnt == LIMIT-1`: `Z <= s`, `cnt <= 0`, `CHG <= 1`.
  - If `s != Z` and `cnt < LIMIT-1`: `cnt <= cnt+1`, `CHG <= 0`.
- **Agreement resets the count.** Any single agreeing sample clears `cnt`, so mismatches need not be contiguous only in the raw input; the count is taken after synchronization.
- **`LIMIT=1`.** Every mismatch is accepted immediately; the block degenerates to a synchronizer plus one register.
- **Counter bounds.** `cnt` never exceeds `LIMIT-1`; no wrap-around is reachable.
- **Reset.** `RN` low, asynchronous, at any time including mid-count:
  - `sync[*] = RST_VAL`, `Z = RST_VAL`, `cnt = 0`, `CHG = 0`.
  - Release is synchronous in effect: the first evaluating edge is the first `CLK` rise with `RN` high.
- **Supplies.** `VDD`/`VSS` are pass-through inouts; no logic depends on them.

## Timing
- **Outputs.** All outputs are registered; no combinational path from `I` or `RN`-release to `Z`/`CHG` (except async reset assertion).
- **Step latency.** Call edge 0 the first edge sampling a new stable `I`.
  - `s` updates after edge `SYNC_STAGES-1`.
  - Mismatches are counted at edges `SYNC_STAGES` .. `SYNC_STAGES+LIMIT-1`.
  - `Z` and `CHG` update after edge `SYNC_STAGES+LIMIT-1`, i.e. the (`SYNC_STAGES+LIMIT`)-th edge. Defaults: 10th edge.
- **`CHG`.** High for exactly one cycle, coincident with the first cycle `Z` shows the new level.
- **Glitch rejection.** Any input pulse shorter than `LIMIT` cycles as seen at `s` produces no `Z` change. An input pulse of exactly `LIMIT` cycles at `s` is accepted.
- **Return after acceptance.** If `I` returns immediately after acceptance, the reverse transition again needs the full `LIMIT` mismatches.
- **Throughput.** Minimum spacing between two `CHG` pulses is `LIMIT` cycles.

## Test plan
- **Reset values.** Hold `RN=0` with `I` toggling; check `Z=0` and `CHG=0` throughout. Release `RN`, hold `I=0` for 20 cycles: no `CHG`.
- **Clean step.** Defaults; `I` 0→1 before edge 0. Required: `Z=0` through edge 8; `Z=1` and `CHG=1` after edge 9; `CHG=0` after edge 10.
- **Glitch rejection.** `I=1` for 7 cycles then 0. Required: `Z` stays 0, `CHG` never asserts, `cnt` back to 0. Repeat with 8 cycles: `Z` rises after edge 9 then needs 8 more mismatches to fall.
- **`LIMIT=1`, `SYNC_STAGES=3`.** Step on `I`. Required: `Z` changes after edge 3 with `CHG` pulse. Alternating `I` every 2 cycles: `Z` tracks `I` delayed 4 cycles.
- **Reset mid-count.** Step `I` to 1, assert `RN=0` asynchronously between edges 6 and 7, release with `I` still 1. Required: `Z=0` immediately on assertion, and the full 10-edge latency restarts from the first edge after release.
- **`RST_VAL=1`.** Reset, then hold `I=1`. Required: `Z=1`, no `CHG`. Falling step yields `Z=0` after the 10th edge.
